// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in one bit per clock, LSB first,
// through a single full-subtractor stage, then presents the result with a one-cycle done pulse.

module fullsubtractor_struct (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    logic ab_xor;
    logic borrow_gen;
    logic borrow_prop;

    assign ab_xor      = a ^ b;
    assign diff        = ab_xor ^ borrow_in;
    assign borrow_gen  = ~a & b;
    // An incoming borrow passes through only when the two operand bits are equal.
    assign borrow_prop = ~ab_xor & borrow_in;
    assign borrow_out  = borrow_gen | borrow_prop;

endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic             borrow_out_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             stage_diff;
    logic             stage_borrow;
    logic [WIDTH-1:0] res_shifted;
    logic             last_bit;

    fullsubtractor_struct u_stage (
        .a          (a_reg[0]),
        .b          (b_reg[0]),
        .borrow_in  (borrow_reg),
        .diff       (stage_diff),
        .borrow_out (stage_borrow)
    );

    // New result bit enters at the MSB so the completed word is aligned after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shifted = stage_diff;
        end else begin : g_res_wn
            assign res_shifted = {stage_diff, res_reg[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            res_reg        <= '0;
            diff_reg       <= '0;
            borrow_reg     <= 1'b0;
            borrow_out_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        borrow_reg <= borrow_in;
                        cnt_reg    <= '0;
                    end
                end
                SHIFT: begin
                    a_reg      <= a_reg >> 1;
                    b_reg      <= b_reg >> 1;
                    res_reg    <= res_shifted;
                    borrow_reg <= stage_borrow;
                    cnt_reg    <= cnt_reg + CNT_W'(1);
                    if (last_bit) begin
                        diff_reg       <= res_shifted;
                        borrow_out_reg <= stage_borrow;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_reg == SHIFT);
    assign done       = (state_reg == DONE);
    assign diff       = diff_reg;
    assign borrow_out = borrow_out_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8, exhaustive WIDTH=4 and WIDTH=1
// instances, with immediate assertions at every comparison point.

module tb_serial_subtractor;

    logic       clk;
    int         n_tests;
    int         n_fail;

    logic       rst8, start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       rst4, start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;
    logic       rst1, start1, bin1, busy1, done1, bout1;
    logic [0:0] a1, b1, diff1;

    logic [7:0] dtbl;
    logic [7:0] btbl;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst8), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bout8)
    );

    serial_subtractor #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst4), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bout4)
    );

    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst1), .start(start1), .a(a1), .b(b1), .borrow_in(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; glitch >= 0 pulses start with junk operands in that SHIFT cycle.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input logic [7:0] ed, input logic eb, input int glitch);
        logic [7:0] diff_before;
        logic       bout_before;
        logic       moved;
        int         cyc;
        int         extra;
        diff_before = diff8;
        bout_before = bout8;
        moved = 1'b0;
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        a8 = ~av; b8 = ~bv; bin8 = ~bi;
        check({tag, "_busy_after_start"}, 32'(busy8), 32'd1);
        cyc = 0;
        while (!done8 && cyc < 20) begin
            start8 = (cyc == glitch);
            if (cyc == glitch) begin
                a8 = 8'h00; b8 = 8'hFF;
            end
            tick;
            cyc++;
            if (busy8 && (diff8 !== diff_before || bout8 !== bout_before)) moved = 1'b1;
        end
        start8 = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'd8);
        check({tag, "_diff"}, 32'(diff8), 32'(ed));
        check({tag, "_borrow"}, 32'(bout8), 32'(eb));
        check({tag, "_busy_in_done"}, 32'(busy8), 32'd0);
        check({tag, "_hold_during_shift"}, 32'(moved), 32'd0);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (busy8 || done8) extra++;
        end
        check({tag, "_quiet_after"}, 32'(extra), 32'd0);
        check({tag, "_diff_held"}, 32'(diff8), 32'(ed));
        $display("[TB] w8 %s a=%02h b=%02h bin=%0d -> diff=%02h borrow=%0d cycles=%0d",
                 tag, av, bv, bi, diff8, bout8, cyc + 1);
    endtask

    initial begin
        int cyc;
        int cnt;
        logic overlap;
        n_tests = 0;
        n_fail  = 0;
        dtbl = 8'b10010110;
        btbl = 8'b10001110;

        // Reset with start held high: start must be ignored.
        rst8 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
        start8 = 1'b1; start4 = 1'b0; start1 = 1'b0;
        a8 = 8'h55; b8 = 8'h22; bin8 = 1'b1;
        a4 = '0; b4 = '0; bin4 = 1'b0;
        a1 = '0; b1 = '0; bin1 = 1'b0;
        tick;
        tick;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_borrow", 32'(bout8), 32'd0);
        check("rst_w4_diff", 32'(diff4), 32'd0);
        check("rst_w1_busy", 32'(busy1), 32'd0);
        rst8 = 1'b1; rst4 = 1'b1; rst1 = 1'b1;
        start8 = 1'b0;
        tick;
        check("start_during_rst_ignored", 32'(busy8), 32'd0);

        op8("basic",    8'h05, 8'h03, 1'b0, 8'h02, 1'b0, -1);
        op8("neg",      8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, -1);
        op8("zero_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, -1);
        op8("ff_bin",   8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1);
        op8("midstart", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 3);

        // Abort in the fourth SHIFT cycle.
        a8 = 8'h3C; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick; tick; tick;
        rst8 = 1'b0;
        tick;
        rst8 = 1'b1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_diff", 32'(diff8), 32'd0);
        check("abort_borrow", 32'(bout8), 32'd0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done8 || busy8) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        $display("[TB] w8 abort mid-shift, outputs cleared");
        op8("after_abort", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, -1);

        // WIDTH=4 exhaustive, start held so each new operation begins right after DONE.
        start4 = 1'b1;
        for (int idx = 0; idx < 512; idx++) begin
            int av;
            int bv;
            int bi;
            av = idx >> 5;
            bv = (idx >> 1) & 15;
            bi = idx & 1;
            a4 = 4'(av); b4 = 4'(bv); bin4 = 1'(bi);
            cyc = 0;
            overlap = 1'b0;
            do begin
                tick;
                cyc++;
                if (busy4 && done4) overlap = 1'b1;
            end while (!done4 && cyc < 20);
            check("w4_interval", 32'(cyc), (idx == 0) ? 32'd5 : 32'd6);
            check("w4_diff", 32'(diff4), 32'((av - bv - bi) & 15));
            check("w4_borrow", 32'(bout4), 32'(av < bv + bi));
            check("w4_busy_done_overlap", 32'(overlap), 32'd0);
            $display("[TB] w4 a=%0h b=%0h bin=%0d -> diff=%0h borrow=%0d", av, bv, bi, diff4, bout4);
        end
        start4 = 1'b0;
        tick;
        tick;

        // WIDTH=1 truth table.
        for (int idx = 0; idx < 8; idx++) begin
            a1 = 1'((idx >> 2) & 1);
            b1 = 1'((idx >> 1) & 1);
            bin1 = 1'(idx & 1);
            start1 = 1'b1;
            tick;
            start1 = 1'b0;
            check("w1_busy", 32'(busy1), 32'd1);
            cyc = 1;
            while (!done1 && cyc < 10) begin
                tick;
                cyc++;
            end
            check("w1_latency", 32'(cyc), 32'd2);
            check("w1_diff", 32'(diff1), 32'(dtbl[idx]));
            check("w1_borrow", 32'(bout1), 32'(btbl[idx]));
            $display("[TB] w1 a=%0d b=%0d bin=%0d -> diff=%0d borrow=%0d", a1, b1, bin1, diff1, bout1);
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 1..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend, captured on accepted start.
REQ-006 b  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 borrow_in  input  1  initial borrow, captured on accepted start.
REQ-008 busy  output  1  high while an operation is in progress (SHIFT state).
REQ-009 done  output  1  single-cycle pulse marking a valid result.
REQ-010 diff  output  WIDTH  result of a - b - borrow_in, modulo 2^WIDTH.
REQ-011 borrow_out  output  1  final borrow; high iff a < b + borrow_in (unsigned).

Function
REQ-012 The block SHALL compute the difference bit-serially, LSB first, one bit per clock, using one instance of fullsubtractor_struct (ports a, b, borrow_in, diff, borrow_out) as the per-bit stage.
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE -> SHIFT when start=1; on that edge a, b load into shift registers, borrow_in loads into the borrow flop, bit counter clears to 0.
REQ-015 IDLE with start=0 SHALL hold all registers unchanged.
REQ-016 Each SHIFT cycle: stage inputs are operand LSBs and borrow flop; stage diff shifts into result register MSB (result shifts right); operands shift right; stage borrow_out loads borrow flop; counter increments.
REQ-017 SHIFT -> DONE on the edge where the counter reaches WIDTH-1 (i.e. after exactly WIDTH bit cycles).
REQ-018 On the SHIFT->DONE edge, diff SHALL load the completed result register and borrow_out SHALL load the final borrow.
REQ-019 DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
REQ-020 Latency: start sampled high at edge N -> done high in cycle after edge N+WIDTH, i.e. WIDTH+1 cycles start-to-done; back-to-back throughput one result per WIDTH+2 cycles.
REQ-021 start while in SHIFT or DONE SHALL be ignored, with no effect on the operation in progress or on later state.
REQ-022 Changes to a, b, borrow_in after the accepted start SHALL not affect the result.
REQ-023 diff and borrow_out SHALL hold their last completed values until the next completion; they SHALL not change during SHIFT.
REQ-024 busy=1 exactly in SHIFT; busy and done SHALL never be high together.
REQ-025 WIDTH=1: SHIFT lasts one cycle; behaviour identical to single full-subtractor evaluation, registered.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, borrow flop=0, operand/result registers=0.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no done pulse SHALL follow, and outputs SHALL read 0.
REQ-028 start sampled on the same edge as rst_n=0 SHALL be ignored; first acceptable start is the first edge with rst_n=1.

Verification (WIDTH=8 unless stated)
REQ-029 a=0x05, b=0x03, borrow_in=0 -> done after 9 cycles, diff=0x02, borrow_out=0.
REQ-030 a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1; a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1; a=0xFF, b=0xFF, borrow_in=1 -> diff=0xFF, borrow_out=1.
REQ-031 Start a=0x80, b=0x01; pulse start with a=0x00, b=0xFF mid-SHIFT -> single done, diff=0x7F, borrow_out=0, busy never re-asserts without new IDLE start.
REQ-032 Start, drop rst_n at cycle 4 of SHIFT for one edge -> IDLE, outputs 0, no done; new start a=0x10, b=0x01 -> diff=0x0F, borrow_out=0.
REQ-033 Exhaustive: WIDTH=4, all 512 (a, b, borrow_in) combinations, back-to-back starts on done -> diff=(a-b-borrow_in) mod 16, borrow_out=(a<b+borrow_in), busy/done timing per REQ-020.
REQ-034 WIDTH=1: all 8 input combinations -> diff/borrow_out match full-subtractor truth table, done 2 cycles after start.
